dpram_be_init: RTL

//  True dual-port synchronous RAM with per-byte write enables on both ports.

---
 rtl/dpram_be_init.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dpram_be_init.sv
// True dual-port synchronous RAM with per-byte write enables, optional output
// register, selectable same-port read-during-write behaviour and a post-reset
// clear sweep that writes init_value to every word.
module dpram_be_init #(
  parameter int unsigned addr_width     = 8,
  parameter int unsigned data_width     = 8,
  parameter int unsigned byte_width     = 8,
  parameter int unsigned out_reg        = 0,
  parameter int unsigned rdw_new        = 0,
  parameter int unsigned clear_on_reset = 1,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               busy,
  input  logic [addr_width-1:0]              address_a,
  input  logic [data_width-1:0]              data_a,
  input  logic [data_width/byte_width-1:0]   byteena_a,
  input  logic                               wren_a,
  input  logic                               enable_a,
  input  logic                               cs_a,
  output logic [data_width-1:0]              q_a,
  input  logic [addr_width-1:0]              address_b,
  input  logic [data_width-1:0]              data_b,
  input  logic [data_width/byte_width-1:0]   byteena_b,
  input  logic                               wren_b,
  input  logic                               enable_b,
  input  logic                               cs_b,
  output logic [data_width-1:0]              q_b
);

  localparam int unsigned depth = 2 ** addr_width;
  localparam int unsigned nb    = data_width / byte_width;

  typedef enum logic {S_RUN, S_CLEAR} state_t;

  state_t                  state, state_next;
  logic [addr_width-1:0]   cnt, cnt_next;
  logic                    busy_next;

  logic [data_width-1:0]   mem [depth];
  logic [data_width-1:0]   merged_a, merged_b;
  logic [data_width-1:0]   rd_a, rd_b;
  logic                    we_a, we_b;

  assign we_a = enable_a & wren_a & cs_a & ~busy;
  assign we_b = enable_b & wren_b & cs_b & ~busy;

  // State, sweep counter and busy flag; reset restarts the sweep at word 0
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (clear_on_reset != 0) ? S_CLEAR : S_RUN;
      cnt   <= '0;
      busy  <= (clear_on_reset != 0);
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
    end
  end

  // Next-state logic: CLEAR walks every address once, then hands over to RUN
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy_next  = 1'b0;
    case (state)
      S_CLEAR: begin
        cnt_next  = cnt + addr_width'(1);
        busy_next = 1'b1;
        if (cnt == '1) begin
          state_next = S_RUN;
          busy_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Memory writes; port A is applied last so it wins per lane on a collision
  always_ff @(posedge clock) begin
    if (busy) begin
      if (!reset) mem[cnt] <= init_value;
    end else begin
      if (we_b) begin
        for (int unsigned i = 0; i < nb; i++) begin
          if (byteena_b[i]) mem[address_b][i*byte_width +: byte_width] <= data_b[i*byte_width +: byte_width];
        end
      end
      if (we_a) begin
        for (int unsigned i = 0; i < nb; i++) begin
          if (byteena_a[i]) mem[address_a][i*byte_width +: byte_width] <= data_a[i*byte_width +: byte_width];
        end
      end
    end
  end

  // Post-write view of each port's own word, used for new-data read-during-write
  always_comb begin
    merged_a = mem[address_a];
    merged_b = mem[address_b];
    for (int unsigned i = 0; i < nb; i++) begin
      if (we_a && byteena_a[i]) merged_a[i*byte_width +: byte_width] = data_a[i*byte_width +: byte_width];
      if (we_b && byteena_b[i]) merged_b[i*byte_width +: byte_width] = data_b[i*byte_width +: byte_width];
    end
  end

  // First read stage; held at zero while the clear sweep runs
  always_ff @(posedge clock) begin
    if (reset || busy) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      if (enable_a) rd_a <= (rdw_new != 0) ? merged_a : mem[address_a];
      if (enable_b) rd_b <= (rdw_new != 0) ? merged_b : mem[address_b];
    end
  end

  generate
    if (out_reg != 0) begin : g_out_reg
      // Optional second stage, advancing only with its port enable
      always_ff @(posedge clock) begin
        if (reset || busy) begin
          q_a <= '0;
          q_b <= '0;
        end else begin
          if (enable_a) q_a <= rd_a;
          if (enable_b) q_b <= rd_b;
        end
      end
    end else begin : g_no_out_reg
      assign q_a = rd_a;
      assign q_b = rd_b;
    end
  endgenerate

endmodule
